seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits. It latches a packed hex value, scans the digits one at a time at a programmable rate, and drives a shared segment bus plus one-hot digit selects. It sits between the ALU result registers and the board display pins, replacing per-digit static decoders with one decoder and a scan controller.

## Interface
- DIGITS, 4: number of digits scanned; ≥1.
- PRESCALE, 50000: clock cycles each digit stays lit; ≥1.
- ACTIVE_LOW, 1: 1 = Seg and Anode outputs active-low; 0 = active-high.

- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Value  in  4*DIGITS  packed nibbles; nibble i shown on digit i (digit 0 = least significant).
- Load  in  1  capture Value into shadow register this edge.
- Enable  in  1  1 = scanning; 0 = display dark, scan frozen.
- Blank  in  DIGITS  per-digit forced blank (bit i blanks digit i), sampled live.
- Seg  out  7  segment bus, bit 0 = a … bit 6 = g, registered.
- Anode  out  DIGITS  one-hot digit select, registered.
- Frame  out  1  one-cycle pulse when scan returns to digit 0.

## Operation
- Shadow register: Value captured on any edge with Load=1, regardless of Enable; display never reads Value directly.
- Prescaler counts 0..PRESCALE-1 while Enable=1; at terminal count it wraps to 0 and the digit index advances; index DIGITS-1 wraps to 0.
- Glyphs (active-high form, gfedcba): 0→3F 1→06 2→5B 3→4F 4→66 5→6D 6→7D 7→07 8→7F 9→6F A→77 b→7C C→39 d→5E E→79 F→71. All 7 bits inverted when ACTIVE_LOW=1.
- Each cycle, output register loads: Anode = one-hot(index) and Seg = glyph(shadow nibble[index]); if Blank[index]=1, Seg = all segments off, Anode still selected.
- Enable=0: prescaler and index hold; Seg and Anode = all off (inactive level). Enable re-asserted: scanning resumes from the held index and count.
- Frame = 1 for the single cycle in which Anode first selects digit 0 after a wrap from DIGITS-1; not asserted at reset release. DIGITS=1: Frame pulses every PRESCALE cycles.

## Timing
- Reset (async assert, sync-safe release): prescaler 0, index 0, shadow 0, Seg all off, Anode all off, Frame 0.
- First cycle after release with Enable=1: Anode selects digit 0, Seg shows glyph 0 (shadow = 0).
- Index advances on the edge where prescaler = PRESCALE-1; Anode/Seg reflect new digit one cycle later. Each digit lit exactly PRESCALE cycles; full frame = DIGITS*PRESCALE cycles.
- Load→Seg latency: 2 edges (shadow, then output register) for the currently selected digit.
- Load coincident with index advance: new shadow data and new index both take effect in the same output update.
- Reset asserted mid-scan: all outputs go inactive immediately (asynchronous).
- PRESCALE=1: digit advances every cycle.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking. Digits above the most-significant non-zero shadow nibble are blanked (ORed with Blank); digit 0 is never suppressed, so value 0 shows a single "0". Computed from shadow, so changes take effect with the Load latency.
- Undefined: every digit shows its nibble unless Blank is set; no extra logic.

## Structure
- Package seg7_pkg: glyph constants for 0–F, SEG_OFF constant, function applying ACTIVE_LOW polarity.
- Sub-module seg7_glyph: combinational 4-bit → 7-bit active-high decoder; instantiated once on the muxed nibble.
- Prescaler width $clog2(PRESCALE) (minimum 1); index width $clog2(DIGITS) (minimum 1).

## Test plan
- Reset, DIGITS=4, PRESCALE=3, Load Value=16'h1A2F, Enable=1 → digits 0..3 show ~71,~5B,~77,~06 (ACTIVE_LOW), each 3 cycles, Anode 1110,1101,1011,0111; Frame pulses every 12 cycles.
- Enable dropped mid-digit 2 for 5 cycles → Seg=7F, Anode=1111; on resume digit 2 completes its remaining count.
- Blank=4'b0100 → digit 2 Seg=7F with Anode=1011; other digits unchanged.
- Load 16'h00FF coincident with index advance → next output shows new nibble for new digit; no stale glyph.
- SEG7_LZB_EN, Value=16'h0000 then 16'h0030 → only digit 0 lit ("0"); then digits 0–1 lit ("30"), digits 2–3 dark.
- Reset_n pulsed low mid-frame → Seg/Anode inactive immediately, Frame=0, restart at digit 0 showing glyph 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants and polarity helper for the seg7 scan driver.
// Glyphs are stored active-high in gfedcba order.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0 = 7'h3F;
  localparam seg_t GLYPH_1 = 7'h06;
  localparam seg_t GLYPH_2 = 7'h5B;
  localparam seg_t GLYPH_3 = 7'h4F;
  localparam seg_t GLYPH_4 = 7'h66;
  localparam seg_t GLYPH_5 = 7'h6D;
  localparam seg_t GLYPH_6 = 7'h7D;
  localparam seg_t GLYPH_7 = 7'h07;
  localparam seg_t GLYPH_8 = 7'h7F;
  localparam seg_t GLYPH_9 = 7'h6F;
  localparam seg_t GLYPH_A = 7'h77;
  localparam seg_t GLYPH_B = 7'h7C;
  localparam seg_t GLYPH_C = 7'h39;
  localparam seg_t GLYPH_D = 7'h5E;
  localparam seg_t GLYPH_E = 7'h79;
  localparam seg_t GLYPH_F = 7'h71;

  localparam seg_t SEG_OFF = 7'h00;

  function automatic seg_t seg_polarity(input seg_t seg, input bit active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between the value source and the seg7 scan driver.
// The master supplies value/control, the slave (driver) returns pin levels.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] Value;
  logic                Load;
  logic                Enable;
  logic [DIGITS-1:0]   Blank;
  logic [6:0]          Seg;
  logic [DIGITS-1:0]   Anode;
  logic                Frame;

  modport master (
    output Value, Load, Enable, Blank,
    input  Seg, Anode, Frame
  );

  modport slave (
    input  Value, Load, Enable, Blank,
    output Seg, Anode, Frame
  );

endinterface

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-high 7-segment (gfedcba) decoder.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       glyph
);

  always_comb begin
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with shadowed value and one shared decoder.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
)(
  input  logic               Clk,
  input  logic               Reset_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     LAST_CNT = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
  localparam seg_t              SEG_IDLE = seg_polarity(SEG_OFF, ACTIVE_LOW);
  localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{ACTIVE_LOW}};

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                frame_pend;
  logic                wrap;

  logic [3:0]          nibble;
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   blank_mask;
  logic                blank_now;
  seg_t                glyph;

  seg_t                seg_q;
  logic [DIGITS-1:0]   anode_q;
  logic                frame_q;

`ifdef SEG7_LZB_EN
  // A digit is suppressed when it and every digit above it hold zero; digit 0 always shows.
  logic [DIGITS-1:0] lz_mask;
  logic              upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shadow[4*i +: 4] == 4'h0);
      lz_mask[i] = upper_zero;
    end
  end

  assign blank_mask = bus.Blank | lz_mask;
`else
  assign blank_mask = bus.Blank;
`endif

  always_comb begin
    nibble    = 4'h0;
    onehot    = '0;
    blank_now = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble    = shadow[4*i +: 4];
        onehot[i] = 1'b1;
        blank_now = blank_mask[i];
      end
    end
  end

  seg7_glyph u_glyph (
    .nibble (nibble),
    .glyph  (glyph)
  );

  assign wrap = (cnt == LAST_CNT) && (idx == LAST_IDX);

  // Frame is deferred one edge after the wrap so it lines up with digit 0 appearing on the pins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow     <= '0;
      cnt        <= '0;
      idx        <= '0;
      frame_pend <= 1'b0;
      seg_q      <= SEG_IDLE;
      anode_q    <= AN_IDLE;
      frame_q    <= 1'b0;
    end else begin
      if (bus.Load) begin
        shadow <= bus.Value;
      end
      if (bus.Enable) begin
        if (cnt == LAST_CNT) begin
          cnt <= '0;
          if (idx == LAST_IDX) begin
            idx <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        frame_pend <= wrap;
        frame_q    <= frame_pend;
        seg_q      <= seg_polarity(blank_now ? SEG_OFF : glyph, ACTIVE_LOW);
        anode_q    <= ACTIVE_LOW ? ~onehot : onehot;
      end else begin
        frame_q <= 1'b0;
        seg_q   <= SEG_IDLE;
        anode_q <= AN_IDLE;
      end
    end
  end

  assign bus.Seg   = seg_q;
  assign bus.Anode = anode_q;
  assign bus.Frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=4, PRESCALE=3, active-low).
// Leading-zero expectations follow SEG7_LZB_EN when the bench is built with it.
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef SEG7_LZB_EN
  localparam logic [6:0] HI_ZERO = 7'h7F;
`else
  localparam logic [6:0] HI_ZERO = 7'h40;
`endif

  seg7_scan_driver_if #(.DIGITS(4)) dut_if ();

  seg7_scan_driver #(
    .DIGITS     (4),
    .PRESCALE   (3),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (dut_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic load,
                               input logic enable, input logic [3:0] blank);
    dut_if.Value  = value;
    dut_if.Load   = load;
    dut_if.Enable = enable;
    dut_if.Blank  = blank;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] exp_seg,
                             input logic [3:0] exp_an, input logic exp_frame);
    checks++;
    assert (dut_if.Seg === exp_seg) else begin
      failures++;
      $error("[TB] FAIL %s seg observed=%h expected=%h", tag, dut_if.Seg, exp_seg);
    end
    checks++;
    assert (dut_if.Anode === exp_an) else begin
      failures++;
      $error("[TB] FAIL %s anode observed=%b expected=%b", tag, dut_if.Anode, exp_an);
    end
    checks++;
    assert (dut_if.Frame === exp_frame) else begin
      failures++;
      $error("[TB] FAIL %s frame observed=%b expected=%b", tag, dut_if.Frame, exp_frame);
    end
  endtask

  task automatic stepCheck(input string tag, input int n, input logic [6:0] exp_seg,
                           input logic [3:0] exp_an, input logic exp_frame);
    for (int k = 0; k < n; k++) begin
      tick();
      checkOutput(tag, exp_seg, exp_an, exp_frame);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(16'h1A2F, 1'b1, 1'b1, 4'b0000);

    // Held in reset: outputs inactive, shadow not loaded despite Load.
    stepCheck("reset_hold", 2, 7'h7F, 4'hF, 1'b0);
    rst_n = 1'b1;

    // E1 shows glyph 0 from the cleared shadow while 1A2F is captured.
    stepCheck("first_digit0", 1, 7'h40, 4'hE, 1'b0);
    applyStimulus(16'h1A2F, 1'b0, 1'b1, 4'b0000);
    stepCheck("d0_F", 2, 7'h0E, 4'hE, 1'b0);
    stepCheck("d1_2", 3, 7'h24, 4'hD, 1'b0);
    stepCheck("d2_A", 3, 7'h08, 4'hB, 1'b0);
    stepCheck("d3_1", 3, 7'h79, 4'h7, 1'b0);
    stepCheck("frame_pulse", 1, 7'h0E, 4'hE, 1'b1);
    stepCheck("d0_after_frame", 2, 7'h0E, 4'hE, 1'b0);
    stepCheck("d1_second", 3, 7'h24, 4'hD, 1'b0);
    stepCheck("d2_before_pause", 1, 7'h08, 4'hB, 1'b0);

    // Pause one cycle into digit 2; it must finish its remaining two cycles afterwards.
    applyStimulus(16'h1A2F, 1'b0, 1'b0, 4'b0000);
    stepCheck("paused_dark", 5, 7'h7F, 4'hF, 1'b0);
    applyStimulus(16'h1A2F, 1'b0, 1'b1, 4'b0000);
    stepCheck("d2_resume", 2, 7'h08, 4'hB, 1'b0);
    stepCheck("d3_resume", 3, 7'h79, 4'h7, 1'b0);
    stepCheck("frame_after_pause", 1, 7'h0E, 4'hE, 1'b1);

    applyStimulus(16'h1A2F, 1'b0, 1'b1, 4'b0100);
    stepCheck("blank_d0", 2, 7'h0E, 4'hE, 1'b0);
    stepCheck("blank_d1", 3, 7'h24, 4'hD, 1'b0);
    stepCheck("blank_d2", 3, 7'h7F, 4'hB, 1'b0);
    stepCheck("blank_d3", 1, 7'h79, 4'h7, 1'b0);
    applyStimulus(16'h1A2F, 1'b0, 1'b1, 4'b0000);
    stepCheck("d3_unblanked", 2, 7'h79, 4'h7, 1'b0);
    stepCheck("frame_third", 1, 7'h0E, 4'hE, 1'b1);
    stepCheck("d0_third", 2, 7'h0E, 4'hE, 1'b0);
    stepCheck("d1_third", 2, 7'h24, 4'hD, 1'b0);

    // Load lands on the same edge that advances digit 1 -> 2.
    applyStimulus(16'h00FF, 1'b1, 1'b1, 4'b0000);
    stepCheck("load_edge_old", 1, 7'h24, 4'hD, 1'b0);
    applyStimulus(16'h00FF, 1'b0, 1'b1, 4'b0000);
    stepCheck("load_new_d2", 3, 7'h40, 4'hB, 1'b0);
    stepCheck("load_new_d3", 3, 7'h40, 4'h7, 1'b0);
    stepCheck("frame_new", 1, 7'h0E, 4'hE, 1'b1);

    // Asynchronous reset between edges must clear outputs, including the live Frame.
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 7'h7F, 4'hF, 1'b0);
    stepCheck("reset_held_mid", 1, 7'h7F, 4'hF, 1'b0);
    rst_n = 1'b1;
    stepCheck("restart_d0", 3, 7'h40, 4'hE, 1'b0);

    // Value 0 then 0030: upper digits depend on leading-zero blanking.
    applyStimulus(16'h0030, 1'b1, 1'b1, 4'b0000);
    stepCheck("zero_d1", 1, HI_ZERO, 4'hD, 1'b0);
    applyStimulus(16'h0030, 1'b0, 1'b1, 4'b0000);
    stepCheck("val30_d1", 2, 7'h30, 4'hD, 1'b0);
    stepCheck("val30_d2", 3, HI_ZERO, 4'hB, 1'b0);
    stepCheck("val30_d3", 3, HI_ZERO, 4'h7, 1'b0);
    stepCheck("val30_d0", 1, 7'h40, 4'hE, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
